uart_result_streamer: RTL

- Transmit-side counterpart to the UART receive packer that assembles the 288-bit input map.
- Latches a wide result word from the controller in one cycle.
- Serialises it into a framed byte stream: header byte, payload bytes LSB-first, 8-bit additive checksum.
- Drives the byte-wide out_en/out_data/out_free interface of uart_codec_top; pacing is set by the codec's free flag.

---
 rtl/uart_result_streamer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_result_streamer.sv
// Frames a wide result word as HEADER, payload bytes LSB-first, then an 8-bit additive checksum,
// and paces the bytes into the UART codec using its free flag.
module uart_result_streamer #(
   parameter int unsigned NUM_BYTES = 36,
   parameter logic [7:0]  HEADER    = 8'hA5,
   parameter int unsigned HOLDOFF   = 4
) (
   input  logic                   clk200M,
   input  logic                   rstn,
   input  logic                   load,
   input  logic [NUM_BYTES*8-1:0] load_data,
   input  logic                   tx_free,
   output logic                   tx_en,
   output logic [7:0]             tx_data,
   output logic                   busy,
   output logic                   done,
   output logic                   dropped
);

   localparam int unsigned IDX_W = $clog2(NUM_BYTES + 2);
   localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [IDX_W-1:0] IDX_CSUM  = IDX_W'(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StHold,
      StWaitFree,
      StFinish
   } state_e;

   state_e                 r_state, w_state_nxt;
   logic [NUM_BYTES*8-1:0] r_payload, w_payload_nxt;
   logic [IDX_W-1:0]       r_idx, w_idx_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [7:0]             r_csum, w_csum_nxt;
   logic                   r_tx_en, w_tx_en_nxt;
   logic [7:0]             r_tx_data, w_tx_data_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_dropped, w_dropped_nxt;

   logic [IDX_W-1:0]       w_pay_idx;
   logic [7:0]             w_pay_byte;
   logic [7:0]             w_cur_byte;
   logic                   w_is_payload;

   // Index 0 is the header, 1..NUM_BYTES the payload, NUM_BYTES+1 the checksum.
   assign w_pay_idx    = r_idx - IDX_W'(1);
   assign w_is_payload = (r_idx != '0) && (r_idx != IDX_CSUM);

   always_comb begin
      w_pay_byte = '0;
      for (int k = 0; k < int'(NUM_BYTES); k++) begin
         if (w_pay_idx == IDX_W'(k)) begin
            w_pay_byte = r_payload[8*k +: 8];
         end
      end
   end

   always_comb begin
      if (r_idx == '0) begin
         w_cur_byte = HEADER;
      end else if (r_idx == IDX_CSUM) begin
         w_cur_byte = r_csum;
      end else begin
         w_cur_byte = w_pay_byte;
      end
   end

   always_ff @(posedge clk200M or negedge rstn) begin
      if (!rstn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: begin
            if (load) begin
               w_state_nxt = StSend;
            end
         end
         StSend: begin
            if (tx_free) begin
               w_state_nxt = StHold;
            end
         end
         StHold: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = StWaitFree;
            end
         end
         StWaitFree: begin
            if (tx_free) begin
               w_state_nxt = (r_idx == IDX_CSUM) ? StFinish : StSend;
            end
         end
         StFinish: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Outputs are computed one cycle ahead and registered, so busy/done follow the next state.
   always_comb begin
      w_payload_nxt = r_payload;
      w_idx_nxt     = r_idx;
      w_cnt_nxt     = r_cnt;
      w_csum_nxt    = r_csum;
      w_tx_en_nxt   = 1'b0;
      w_tx_data_nxt = r_tx_data;
      w_busy_nxt    = (w_state_nxt == StSend) || (w_state_nxt == StHold) ||
                      (w_state_nxt == StWaitFree);
      w_done_nxt    = (w_state_nxt == StFinish);
      w_dropped_nxt = load && (r_state != StIdle);
      case (r_state)
         StIdle: begin
            if (load) begin
               w_payload_nxt = load_data;
               w_idx_nxt     = '0;
               w_csum_nxt    = '0;
            end
         end
         StSend: begin
            if (tx_free) begin
               w_tx_en_nxt   = 1'b1;
               w_tx_data_nxt = w_cur_byte;
               w_cnt_nxt     = '0;
               if (w_is_payload) begin
                  w_csum_nxt = r_csum + w_pay_byte;
               end
            end
         end
         StHold: begin
            if (r_cnt != HOLD_LAST) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         StWaitFree: begin
            if (tx_free && (r_idx != IDX_CSUM)) begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk200M or negedge rstn) begin
      if (!rstn) begin
         r_payload <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_csum    <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_payload <= w_payload_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_csum    <= w_csum_nxt;
         r_tx_en   <= w_tx_en_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_dropped <= w_dropped_nxt;
      end
   end

   assign tx_en   = r_tx_en;
   assign tx_data = r_tx_data;
   assign busy    = r_busy;
   assign done    = r_done;
   assign dropped = r_dropped;

endmodule
